// File: rtl/prog_ram_loader_if.sv
// Loader stream, CPU fetch port and status bundle for prog_ram_loader.
// LOADER_CHECKSUM_EN adds the checksum signal.
interface prog_ram_loader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              load_start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              cpu_hold;
    logic              load_done;
    logic [ADDR_W:0]   load_count;
`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    // Stream handshake: a byte moves on a rising edge where in_valid and in_ready
    // are both 1; the source holds in_data/in_last stable until that edge.
    modport master (
        output load_start, in_valid, in_data, in_last, address,
        input  in_ready, data, cpu_hold, load_done, load_count
`ifdef LOADER_CHECKSUM_EN
        , input checksum
`endif
    );

    modport slave (
        input  load_start, in_valid, in_data, in_last, address,
        output in_ready, data, cpu_hold, load_done, load_count
`ifdef LOADER_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/prog_ram_loader.sv
// Writable program memory with a byte-stream loader that zero-fills the unwritten tail.
// Optional macro LOADER_CHECKSUM_EN adds a running checksum of accepted bytes.
module prog_ram_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    prog_ram_loader_if.slave    bus,
    output logic [1:0]          fsm_state
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, next_state;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W:0]   count;
    logic              done_flag;
    logic              ready;
    logic              hold;
    logic              accept;
    logic              at_end;

    assign accept = ready && bus.in_valid;
    assign at_end = (wr_ptr == LAST_ADDR);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (bus.load_start) next_state = LOAD;
            LOAD: begin
                if (accept) begin
                    if (at_end)           next_state = DONE;
                    else if (bus.in_last) next_state = FILL;
                end
            end
            FILL: if (at_end) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        hold  = 1'b0;
        case (state)
            LOAD: begin
                ready = 1'b1;
                hold  = 1'b1;
            end
            FILL:    hold = 1'b1;
            default: begin
                ready = 1'b0;
                hold  = 1'b0;
            end
        endcase
    end

    // wr_ptr parks on the last address instead of wrapping, so a finished
    // load can never start a second pass over memory.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            done_flag <= 1'b0;
        end else begin
            done_flag <= (next_state == DONE) && (state != DONE);
            case (state)
                IDLE, DONE: begin
                    if (bus.load_start) begin
                        wr_ptr <= '0;
                        count  <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        mem[wr_ptr] <= bus.in_data;
                        if (!at_end) wr_ptr <= wr_ptr + 1'b1;
                        if (count != FULL_COUNT) count <= count + 1'b1;
                    end
                end
                FILL: begin
                    mem[wr_ptr] <= '0;
                    if (!at_end) wr_ptr <= wr_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum <= '0;
        end else if ((state == IDLE || state == DONE) && bus.load_start) begin
            sum <= '0;
        end else if (accept) begin
            sum <= sum + bus.in_data;
        end
    end

    assign bus.checksum = sum;
`endif

    // The CPU sees nops while a load is in flight.
    assign bus.data       = hold ? '0 : mem[bus.address];
    assign bus.in_ready   = ready;
    assign bus.cpu_hold   = hold;
    assign bus.load_done  = done_flag;
    assign bus.load_count = count;
    assign fsm_state      = state;
endmodule

// File: tb/tb_prog_ram_loader.sv
// Directed bench for prog_ram_loader: reset, short/full loads, gaps, abort and reload.
module tb_prog_ram_loader;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] fsm_state;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    prog_ram_loader_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    prog_ram_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
    endtask

    // Hold the byte until the DUT accepts it; returns 1 in ok on acceptance.
    task automatic send_byte(input logic [7:0] b, input logic last, output bit ok);
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        for (int k = 0; k < 50; k++) begin
            if (bus.in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(output int cycles, output bit seen);
        cycles = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.load_done) begin
                seen = 1'b1;
                break;
            end
            tick();
            cycles++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (bus.cpu_hold !== 1'b0) begin
            miscompares++; $display("FAIL reset_cpu_hold got %b want 0", bus.cpu_hold);
        end
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready);
        end
        vectors++;
        if (bus.load_count !== 5'd0) begin
            miscompares++; $display("FAIL reset_load_count got %0d want 0", bus.load_count);
        end
        vectors++;
        if (bus.load_done !== 1'b0 || fsm_state !== 2'd0) begin
            miscompares++; $display("FAIL reset_state got done=%b st=%0d want 0/0", bus.load_done, fsm_state);
        end
        for (int a = 0; a < 16; a++) begin
            bus.address = 4'(a);
            #1;
            vectors++;
            if (bus.data !== 8'h00) begin
                miscompares++; $display("FAIL reset_read addr %0d got %h want 00", a, bus.data);
            end
        end
        tick();
    endtask

    task automatic test_short_load();
        logic [7:0] bytes [4];
        logic [7:0] exp_sum;
        int cycles;
        bit seen, ok;
        bytes[0] = 8'h70; bytes[1] = 8'h90; bytes[2] = 8'h51; bytes[3] = 8'hF1;
        exp_sum = 8'h00;
        pulse_start();
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.cpu_hold !== 1'b1) begin
            miscompares++; $display("FAIL short_enter_load got ready=%b hold=%b want 1/1", bus.in_ready, bus.cpu_hold);
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], i == 3, ok);
            exp_sum = exp_sum + bytes[i];
            vectors++;
            if (ok !== 1'b1) begin
                miscompares++; $display("FAIL short_accept byte %0d got timeout want accept", i);
            end
        end
        wait_done(cycles, seen);
        vectors++;
        if (seen !== 1'b1 || cycles !== 12) begin
            miscompares++; $display("FAIL short_fill_cycles got seen=%b cycles=%0d want 1/12", seen, cycles);
        end
        vectors++;
        if (bus.cpu_hold !== 1'b0) begin
            miscompares++; $display("FAIL short_hold_at_done got %b want 0", bus.cpu_hold);
        end
        tick();
        vectors++;
        if (bus.load_done !== 1'b0 || fsm_state !== 2'd3) begin
            miscompares++; $display("FAIL short_done_pulse got done=%b st=%0d want 0/3", bus.load_done, fsm_state);
        end
        vectors++;
        if (bus.load_count !== 5'd4) begin
            miscompares++; $display("FAIL short_load_count got %0d want 4", bus.load_count);
        end
`ifdef LOADER_CHECKSUM_EN
        vectors++;
        if (bus.checksum !== exp_sum) begin
            miscompares++; $display("FAIL short_checksum got %h want %h", bus.checksum, exp_sum);
        end
`endif
        for (int a = 0; a < 16; a++) begin
            bus.address = 4'(a);
            #1;
            vectors++;
            if (bus.data !== ((a < 4) ? bytes[a] : 8'h00)) begin
                miscompares++; $display("FAIL short_read addr %0d got %h want %h", a, bus.data, (a < 4) ? bytes[a] : 8'h00);
            end
        end
        tick();
    endtask

    task automatic test_full_load();
        int cycles;
        bit seen, ok;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i + 1), 1'b0, ok);
            vectors++;
            if (ok !== 1'b1) begin
                miscompares++; $display("FAIL full_accept byte %0d got timeout want accept", i);
            end
        end
        wait_done(cycles, seen);
        vectors++;
        if (seen !== 1'b1 || cycles !== 0) begin
            miscompares++; $display("FAIL full_no_fill got seen=%b cycles=%0d want 1/0", seen, cycles);
        end
        vectors++;
        if (bus.load_count !== 5'd16) begin
            miscompares++; $display("FAIL full_load_count got %0d want 16", bus.load_count);
        end
`ifdef LOADER_CHECKSUM_EN
        vectors++;
        if (bus.checksum !== 8'h88) begin
            miscompares++; $display("FAIL full_checksum got %h want 88", bus.checksum);
        end
`endif
        for (int a = 0; a < 16; a++) begin
            bus.address = 4'(a);
            #1;
            vectors++;
            if (bus.data !== 8'(a + 1)) begin
                miscompares++; $display("FAIL full_read addr %0d got %h want %h", a, bus.data, 8'(a + 1));
            end
        end
        tick();
    endtask

    task automatic test_reload_single();
        int cycles;
        bit seen, ok;
        pulse_start();
        send_byte(8'h90, 1'b1, ok);
        wait_done(cycles, seen);
        vectors++;
        if (ok !== 1'b1 || seen !== 1'b1 || cycles !== 15) begin
            miscompares++; $display("FAIL single_load got ok=%b seen=%b cycles=%0d want 1/1/15", ok, seen, cycles);
        end
        vectors++;
        if (bus.load_count !== 5'd1) begin
            miscompares++; $display("FAIL single_load_count got %0d want 1", bus.load_count);
        end
        for (int a = 0; a < 16; a++) begin
            bus.address = 4'(a);
            #1;
            vectors++;
            if (bus.data !== ((a == 0) ? 8'h90 : 8'h00)) begin
                miscompares++; $display("FAIL single_read addr %0d got %h want %h", a, bus.data, (a == 0) ? 8'h90 : 8'h00);
            end
        end
        tick();
    endtask

    task automatic test_gaps();
        logic [7:0] exp [16];
        int cycles;
        bit seen, ok;
        for (int a = 0; a < 16; a++) exp[a] = 8'h00;
        exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
        pulse_start();
        send_byte(8'hA1, 1'b0, ok);
        tick();
        bus.address = 4'd0;
        #1;
        vectors++;
        if (bus.data !== 8'h00 || bus.cpu_hold !== 1'b1) begin
            miscompares++; $display("FAIL gaps_read_while_hold got data=%h hold=%b want 00/1", bus.data, bus.cpu_hold);
        end
        tick();
        pulse_start();
        vectors++;
        if (fsm_state !== 2'd1 || bus.load_count !== 5'd1) begin
            miscompares++; $display("FAIL gaps_start_ignored got st=%0d count=%0d want 1/1", fsm_state, bus.load_count);
        end
        tick();
        send_byte(8'hB2, 1'b0, ok);
        tick();
        tick();
        send_byte(8'hC3, 1'b1, ok);
        // A byte offered while in_ready is low must stay unconsumed.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        wait_done(cycles, seen);
        vectors++;
        if (seen !== 1'b1 || cycles !== 13) begin
            miscompares++; $display("FAIL gaps_fill_cycles got seen=%b cycles=%0d want 1/13", seen, cycles);
        end
        tick();
        tick();
        vectors++;
        if (bus.load_count !== 5'd3 || fsm_state !== 2'd3) begin
            miscompares++; $display("FAIL gaps_not_consumed got count=%0d st=%0d want 3/3", bus.load_count, fsm_state);
        end
        bus.in_valid = 1'b0;
        for (int a = 0; a < 16; a++) begin
            bus.address = 4'(a);
            #1;
            vectors++;
            if (bus.data !== exp[a]) begin
                miscompares++; $display("FAIL gaps_read addr %0d got %h want %h", a, bus.data, exp[a]);
            end
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int cycles;
        bit seen, ok, saw_done;
        pulse_start();
        send_byte(8'h11, 1'b0, ok);
        send_byte(8'h22, 1'b0, ok);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (fsm_state !== 2'd0 || bus.cpu_hold !== 1'b0 || bus.in_ready !== 1'b0) begin
            miscompares++; $display("FAIL abort_idle got st=%0d hold=%b ready=%b want 0/0/0", fsm_state, bus.cpu_hold, bus.in_ready);
        end
        vectors++;
        if (bus.load_count !== 5'd0) begin
            miscompares++; $display("FAIL abort_load_count got %0d want 0", bus.load_count);
        end
        saw_done = bus.load_done;
        for (int a = 0; a < 16; a++) begin
            bus.address = 4'(a);
            #1;
            vectors++;
            if (bus.data !== 8'h00) begin
                miscompares++; $display("FAIL abort_read addr %0d got %h want 00", a, bus.data);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            saw_done = saw_done | bus.load_done;
        end
        vectors++;
        if (saw_done !== 1'b0) begin
            miscompares++; $display("FAIL abort_no_done got %b want 0", saw_done);
        end
        pulse_start();
        send_byte(8'h70, 1'b0, ok);
        send_byte(8'hF0, 1'b1, ok);
        wait_done(cycles, seen);
        vectors++;
        if (seen !== 1'b1 || cycles !== 14 || bus.load_count !== 5'd2) begin
            miscompares++; $display("FAIL abort_reload got seen=%b cycles=%0d count=%0d want 1/14/2", seen, cycles, bus.load_count);
        end
        bus.address = 4'd0;
        #1;
        vectors++;
        if (bus.data !== 8'h70) begin
            miscompares++; $display("FAIL abort_reload_addr0 got %h want 70", bus.data);
        end
        bus.address = 4'd1;
        #1;
        vectors++;
        if (bus.data !== 8'hF0) begin
            miscompares++; $display("FAIL abort_reload_addr1 got %h want F0", bus.data);
        end
        tick();
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = 8'h00;
        bus.in_last    = 1'b0;
        bus.address    = 4'd0;
        test_reset();
        test_short_load();
        test_full_load();
        test_reload_single();
        test_gaps();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
